perceptron_trainer: RTL and testbench

Parametrised successor to the fixed combinational perceptron classifier. It holds an N_IN-input weight vector plus a bias in registers and evaluates one feature vector at a time with a serial multiply-accumulate. When training is compiled in, it applies the perceptron learning rule on a misclassification. It sits behind the top-level pin wrapper: valid/ready sample input on one side, registered class and score on the other, and a direct port for loading weights.

---
 rtl/perceptron_pkg.sv | 37 +++
 rtl/perceptron_weight_rf.sv | 80 ++++++++
 rtl/perceptron_trainer.sv | 206 ++++++++++++++++++++
 tb/tb_perceptron_trainer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared state type and arithmetic helpers for perceptron_trainer.
// Training support is selected by the PERCEPTRON_TRAIN_EN macro in the consuming modules.
package perceptron_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_DECIDE,
        ST_UPDATE,
        ST_RESP
    } state_t;

    // Accumulator width that holds bias plus N_IN full-scale products without overflow.
    function automatic int unsigned acc_width(input int unsigned n_in,
                                              input int unsigned x_w,
                                              input int unsigned w_w);
        return w_w + x_w + $clog2(n_in + 1) + 1;
    endfunction

    // Signed add clamped to the range of a w-bit two's-complement value.
    function automatic int sat_add(input int a, input int b, input int unsigned w);
        int sum;
        int hi;
        int lo;
        sum = a + b;
        hi  = (1 <<< (w - 1)) - 1;
        lo  = -(1 <<< (w - 1));
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/perceptron_weight_rf.sv
// Weight and bias register file: write port, serial read mux and parallel saturating update.
// The update path exists only when PERCEPTRON_TRAIN_EN is defined.
module perceptron_weight_rf
    import perceptron_pkg::*;
#(
    parameter  int unsigned N_IN = 7,
    parameter  int unsigned X_W  = 4,
    parameter  int unsigned W_W  = 8,
    localparam int unsigned AW   = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic signed [W_W-1:0] wr_data,
    input  logic [AW-1:0]         rd_idx,
    output logic signed [W_W-1:0] rd_weight,
    output logic signed [W_W-1:0] bias,
    input  logic                  upd,
    input  logic                  upd_label,
    input  logic [N_IN*X_W-1:0]   upd_x
);

    logic signed [W_W-1:0] w [N_IN];

`ifdef PERCEPTRON_TRAIN_EN
    logic signed [W_W-1:0] w_upd [N_IN];
    logic signed [W_W-1:0] bias_upd;

    // Label 1 pulls weights toward the sample, label 0 pushes them away.
    always_comb begin
        for (int i = 0; i < int'(N_IN); i++) begin
            if (upd_label) begin
                w_upd[i] = W_W'(sat_add(int'(w[i]), int'(upd_x[i*X_W +: X_W]), W_W));
            end else begin
                w_upd[i] = W_W'(sat_add(int'(w[i]), -int'(upd_x[i*X_W +: X_W]), W_W));
            end
        end
        bias_upd = W_W'(sat_add(int'(bias), upd_label ? 1 : -1, W_W));
    end
`else
    logic unused_upd;
    assign unused_upd = &{1'b0, upd, upd_label, upd_x};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                w[i] <= '0;
            end
            bias <= '0;
`ifdef PERCEPTRON_TRAIN_EN
        end else if (upd) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                w[i] <= w_upd[i];
            end
            bias <= bias_upd;
`endif
        end else if (wr_en) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                if (wr_addr == AW'(i)) begin
                    w[i] <= wr_data;
                end
            end
            if (wr_addr == AW'(N_IN)) begin
                bias <= wr_data;
            end
        end
    end

    always_comb begin
        rd_weight = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (rd_idx == AW'(i)) begin
                rd_weight = w[i];
            end
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Serial-MAC perceptron with valid/ready sample and result ports and a direct weight write port.
// Define PERCEPTRON_TRAIN_EN to build the perceptron learning-rule update.
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter  int unsigned N_IN  = 7,
    parameter  int unsigned X_W   = 4,
    parameter  int unsigned W_W   = 8,
    localparam int unsigned ACC_W = acc_width(N_IN, X_W, W_W),
    localparam int unsigned AW    = $clog2(N_IN + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*X_W-1:0]     in_x,
    input  logic                    in_label,
    input  logic                    in_train,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_class,
    output logic signed [ACC_W-1:0] out_score,
    output logic                    out_updated,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic signed [W_W-1:0]   wr_data
);

    state_t                  state;
    state_t                  state_next;
    logic [N_IN*X_W-1:0]     x_q;
    logic signed [ACC_W-1:0] acc;
    logic [AW-1:0]           idx;
    logic                    class_q;
    logic                    updated;
    logic                    label_q;

    logic                    accept;
    logic                    wr_ok;
    logic                    mac_last;
    logic                    cls_c;
    logic                    do_update;
    logic                    upd_strobe;
    logic [X_W-1:0]          x_sel;
    logic signed [W_W-1:0]   rd_weight;
    logic signed [W_W-1:0]   bias;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] prod;

    assign in_ready = (state == ST_IDLE) && !wr_en && !rst;
    assign accept   = in_valid && in_ready;
    assign wr_ok    = wr_en && (state == ST_IDLE);
    assign mac_last = (idx == AW'(N_IN - 1));
    assign cls_c    = !acc[ACC_W-1];

`ifdef PERCEPTRON_TRAIN_EN
    logic train_q;
    assign do_update = train_q && (cls_c != label_q);
`else
    logic unused_train;
    assign unused_train = &{1'b0, in_train};
    assign do_update    = 1'b0;
`endif

    perceptron_weight_rf #(
        .N_IN (N_IN),
        .X_W  (X_W),
        .W_W  (W_W)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_ok),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_idx    (idx),
        .rd_weight (rd_weight),
        .bias      (bias),
        .upd       (upd_strobe),
        .upd_label (label_q),
        .upd_x     (x_q)
    );

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (idx == AW'(i)) begin
                x_sel = x_q[i*X_W +: X_W];
            end
        end
    end

    // Signed weight times unsigned feature, both widened to the accumulator width.
    assign w_ext = {{(ACC_W - W_W){rd_weight[W_W-1]}}, rd_weight};
    assign x_ext = {{(ACC_W - X_W){1'b0}}, x_sel};
    assign prod  = w_ext * x_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        upd_strobe = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_MAC;
                end
            end
            ST_MAC: begin
                if (mac_last) begin
                    state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                state_next = do_update ? ST_UPDATE : ST_RESP;
            end
`ifdef PERCEPTRON_TRAIN_EN
            ST_UPDATE: begin
                upd_strobe = 1'b1;
                state_next = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (out_valid && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath; RESP spends its first cycle loading the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            acc         <= '0;
            idx         <= '0;
            class_q     <= 1'b0;
            updated     <= 1'b0;
            label_q     <= 1'b0;
`ifdef PERCEPTRON_TRAIN_EN
            train_q     <= 1'b0;
`endif
            out_valid   <= 1'b0;
            out_class   <= 1'b0;
            out_score   <= '0;
            out_updated <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        x_q     <= in_x;
                        acc     <= {{(ACC_W - W_W){bias[W_W-1]}}, bias};
                        idx     <= '0;
                        updated <= 1'b0;
`ifdef PERCEPTRON_TRAIN_EN
                        label_q <= in_label;
                        train_q <= in_train;
`endif
                    end
                end
                ST_MAC: begin
                    acc <= acc + prod;
                    if (!mac_last) begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_DECIDE: begin
                    class_q <= cls_c;
                end
`ifdef PERCEPTRON_TRAIN_EN
                ST_UPDATE: begin
                    updated <= 1'b1;
                end
`endif
                ST_RESP: begin
                    if (!out_valid) begin
                        out_valid   <= 1'b1;
                        out_class   <= class_q;
                        out_score   <= acc;
                        out_updated <= updated;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        updated   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifndef PERCEPTRON_TRAIN_EN
    logic unused_label;
    assign unused_label = &{1'b0, in_label};
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a spec-level score/update model and per-cycle output checker.
// Training cases are exercised when PERCEPTRON_TRAIN_EN is defined.
module tb_perceptron_trainer;

    localparam int N_IN  = 7;
    localparam int X_W   = 4;
    localparam int W_W   = 8;
    localparam int ACC_W = 16;
    localparam int AW    = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [N_IN*X_W-1:0]     in_x;
    logic                    in_label;
    logic                    in_train;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_class;
    logic signed [ACC_W-1:0] out_score;
    logic                    out_updated;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic signed [W_W-1:0]   wr_data;

    always #5 clk = ~clk;

    perceptron_trainer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_label    (in_label),
        .in_train    (in_train),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_score   (out_score),
        .out_updated (out_updated),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   mw [N_IN];
    int   mb;
    int   cur_x [N_IN];
    int   exp_score;
    logic exp_class;
    logic exp_updated;
    int   exp_lat;
    logic track = 1'b0;
    logic seen  = 1'b0;
    int   edges = 0;
    int   last_score;
    logic last_class;
    logic last_updated;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampw(input int v);
        int hi = (1 <<< (W_W - 1)) - 1;
        int lo = -(1 <<< (W_W - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    always @(posedge clk) if (track) edges <= edges + 1;

    // Output checker: every cycle a result is presented it must equal the model's answer.
    always @(negedge clk) begin
        if (out_valid) begin
            chk("valid_expected", track, 1);
            chk("score", int'(out_score), exp_score);
            chk("class", out_class, exp_class);
            chk("updated", out_updated, exp_updated);
            chk("in_ready_in_resp", in_ready, 0);
            if (!seen) begin
                chk("latency", edges, exp_lat);
                seen = 1'b1;
            end
        end
    end

    task automatic wr(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = W_W'(data);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (addr < N_IN) mw[addr] = data;
        else if (addr == N_IN) mb = data;
    endtask

    task automatic clear_weights();
        for (int i = 0; i <= N_IN; i++) wr(i, 0);
    endtask

    task automatic clear_x();
        for (int i = 0; i < N_IN; i++) cur_x[i] = 0;
    endtask

    task automatic run_sample(input logic label, input logic train, input int hold, input logic poke);
        int s;
        logic c;
        logic u;
        int k;
        logic [N_IN*X_W-1:0] px;
        s  = mb;
        px = '0;
        for (int i = 0; i < N_IN; i++) begin
            s += mw[i] * cur_x[i];
            px[i*X_W +: X_W] = X_W'(cur_x[i]);
        end
        c = (s >= 0);
        u = 1'b0;
`ifdef PERCEPTRON_TRAIN_EN
        u = train && (c != label);
`endif
        exp_score   = s;
        exp_class   = c;
        exp_updated = u;
        exp_lat     = N_IN + 2 + (u ? 1 : 0);
        if (u) begin
            for (int i = 0; i < N_IN; i++) mw[i] = clampw(mw[i] + (label ? cur_x[i] : -cur_x[i]));
            mb = clampw(mb + (label ? 1 : -1));
        end
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_x     = px;
        in_label = label;
        in_train = train;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen     = 1'b0;
        edges    = 0;
        track    = 1'b1;
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("valid_seen", out_valid, 1);
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 1) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = 8'sd77;
            end else begin
                wr_en = 1'b0;
            end
            @(posedge clk); #1;
        end
        wr_en        = 1'b0;
        last_score   = int'(out_score);
        last_class   = out_class;
        last_updated = out_updated;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        track     = 1'b0;
        chk("valid_drop", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_x = '0; in_label = 1'b0; in_train = 1'b0;
        out_ready = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < N_IN; i++) mw[i] = 0;
        mb = 0;
        clear_x();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_score", int'(out_score), 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_updated", out_updated, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);

        // Zero weights, all-max features
        for (int i = 0; i < N_IN; i++) cur_x[i] = 15;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("t1_score", last_score, 0);
        chk("t1_class", last_class, 1);
        chk("t1_updated", last_updated, 0);

        clear_x();
        wr(0, 3); wr(1, -5); wr(N_IN, 1);
        cur_x[0] = 2; cur_x[1] = 1;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("t2_score", last_score, 2);
        chk("t2_class", last_class, 1);

        wr(0, -3); wr(1, 0); wr(N_IN, 0);
        clear_x(); cur_x[0] = 1;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("neg_score", last_score, -3);
        chk("neg_class", last_class, 0);

        wr(0, 2); wr(1, -1);
        cur_x[0] = 1; cur_x[1] = 2;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("zero_score", last_score, 0);
        chk("zero_class", last_class, 1);

        for (int i = 0; i <= N_IN; i++) wr(i, -128);
        for (int i = 0; i < N_IN; i++) cur_x[i] = 15;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("min_score", last_score, -13568);
        for (int i = 0; i <= N_IN; i++) wr(i, 127);
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("max_score", last_score, 13462);

        clear_weights();
        wr(N_IN, -1);
        clear_x(); cur_x[0] = 4;
        run_sample(1'b1, 1'b1, 0, 1'b0);
        chk("t3_score", last_score, -1);
        chk("t3_class", last_class, 0);
`ifdef PERCEPTRON_TRAIN_EN
        chk("t3_updated", last_updated, 1);
        run_sample(1'b1, 1'b1, 0, 1'b0);
        chk("t3_rerun_score", last_score, 16);
        chk("t3_rerun_class", last_class, 1);
        chk("t3_rerun_updated", last_updated, 0);

        clear_weights();
        wr(0, 126); wr(1, -128); wr(N_IN, -1);
        clear_x(); cur_x[0] = 5; cur_x[1] = 15;
        run_sample(1'b1, 1'b1, 0, 1'b0);
        chk("sat_hi_score", last_score, -1291);
        chk("sat_hi_updated", last_updated, 1);
        clear_x(); cur_x[0] = 1;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("sat_hi_w0", last_score, 127);

        clear_weights();
        wr(0, -126); wr(1, 127);
        clear_x(); cur_x[0] = 5; cur_x[1] = 15;
        run_sample(1'b0, 1'b1, 0, 1'b0);
        chk("sat_lo_score", last_score, 1275);
        chk("sat_lo_updated", last_updated, 1);
        clear_x(); cur_x[0] = 1;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("sat_lo_w0", last_score, -129);
`else
        chk("t3_updated", last_updated, 0);
        run_sample(1'b1, 1'b1, 0, 1'b0);
        chk("t3_rerun_score", last_score, -1);
`endif

        // Backpressure with an ignored write while the result is held
        clear_weights();
        wr(0, 10);
        clear_x(); cur_x[0] = 3;
        run_sample(1'b0, 1'b0, 5, 1'b1);
        chk("bp_score", last_score, 30);
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("bp_after_score", last_score, 30);

        // Reset during MAC
        wr(0, 5);
        clear_x(); cur_x[0] = 1;
        in_valid = 1'b1; in_x = '0; in_x[X_W-1:0] = 4'd1; in_train = 1'b0; in_label = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < N_IN; i++) mw[i] = 0;
        mb = 0;
        #1;
        chk("midrst_idle", in_ready, 1);
        for (int i = 0; i < N_IN; i++) cur_x[i] = 15;
        run_sample(1'b0, 1'b0, 0, 1'b0);
        chk("midrst_score", last_score, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
